flt_pds2_onboard_result_checker: RTL

On-board result checker for the `flt_pds2` floating-point reciprocal core. It is the receiving end of the on-board self-test. It consumes the core's AXI4-Stream result channel, fetches the golden value for each beat from an expected-value ROM, and compares the two with a configurable ULP tolerance. It accumulates error and timeout status into pass/fail flags that can drive board LEDs.

---
 rtl/flt_pds2_onboard_pkg.sv | 29 ++
 rtl/flt_pds2_result_cmp.sv | 63 ++++++
 rtl/flt_pds2_onboard_result_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/flt_pds2_onboard_pkg.sv
// Shared types and field helpers for the flt_pds2 on-board result checker.
package flt_pds2_onboard_pkg;

  localparam int EXP_W       = 8;
  localparam int MAN_W       = 23;
  localparam int TDATA_OUT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DONE_PASS = 2'd2,
    ST_DONE_FAIL = 2'd3
  } state_t;

  // Exponent all ones with a non-zero mantissa.
  function automatic logic f_is_nan(input logic [63:0] i_w, input int i_exp_w, input int i_man_w);
    logic [63:0] v_exp;
    logic [63:0] v_man;
    v_exp = (i_w >> i_man_w) & ((64'd1 << i_exp_w) - 64'd1);
    v_man = i_w & ((64'd1 << i_man_w) - 64'd1);
    return (v_exp == ((64'd1 << i_exp_w) - 64'd1)) && (v_man != 64'd0);
  endfunction

  // Low EXP+MAN bits as an unsigned magnitude.
  function automatic logic [63:0] f_mag(input logic [63:0] i_w, input int i_exp_w, input int i_man_w);
    return i_w & ((64'd1 << (i_exp_w + i_man_w)) - 64'd1);
  endfunction

endpackage

// File: rtl/flt_pds2_result_cmp.sv
// Registered compare stage: result vs golden value with ULP tolerance and tlast check.
module flt_pds2_result_cmp
  import flt_pds2_onboard_pkg::*;
#(
  parameter int EXP_WIDTH       = EXP_W,
  parameter int MAN_WIDTH       = MAN_W,
  parameter int TDATA_OUT_WIDTH = TDATA_OUT_W,
  parameter int NUM_VECTORS     = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int ULP_TOL         = 1
) (
  input  logic                       i_aclk,
  input  logic                       i_areset_n,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  logic [TDATA_OUT_WIDTH-1:0] i_res,
  input  logic [TDATA_OUT_WIDTH-1:0] i_exp,
  input  logic                       i_tlast,
  input  logic [ADDR_WIDTH-1:0]      i_idx,
  output logic                       o_valid,
  output logic                       o_mismatch,
  output logic [ADDR_WIDTH-1:0]      o_idx
);

  logic [63:0] w_res64;
  logic [63:0] w_exp64;
  logic [63:0] w_mag_r;
  logic [63:0] w_mag_e;
  logic [63:0] w_diff;
  logic        w_both_nan;
  logic        w_both_zero;
  logic        w_sign_eq;
  logic        w_value_ok;
  logic        w_tlast_ok;

  assign w_res64     = 64'(i_res);
  assign w_exp64     = 64'(i_exp);
  assign w_mag_r     = f_mag(w_res64, EXP_WIDTH, MAN_WIDTH);
  assign w_mag_e     = f_mag(w_exp64, EXP_WIDTH, MAN_WIDTH);
  assign w_diff      = (w_mag_r > w_mag_e) ? (w_mag_r - w_mag_e) : (w_mag_e - w_mag_r);
  assign w_both_nan  = f_is_nan(w_res64, EXP_WIDTH, MAN_WIDTH) && f_is_nan(w_exp64, EXP_WIDTH, MAN_WIDTH);
  assign w_both_zero = (w_mag_r == 64'd0) && (w_mag_e == 64'd0);
  assign w_sign_eq   = i_res[EXP_WIDTH+MAN_WIDTH] == i_exp[EXP_WIDTH+MAN_WIDTH];
  assign w_value_ok  = w_both_nan || w_both_zero || (w_sign_eq && (w_diff <= 64'(ULP_TOL)));
  assign w_tlast_ok  = i_tlast == (i_idx == ADDR_WIDTH'(NUM_VECTORS - 1));

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_valid    <= 1'b0;
      o_mismatch <= 1'b0;
      o_idx      <= '0;
    end else if (i_clear) begin
      o_valid    <= 1'b0;
      o_mismatch <= 1'b0;
      o_idx      <= '0;
    end else begin
      o_valid    <= i_valid;
      o_mismatch <= i_valid && !(w_value_ok && w_tlast_ok);
      o_idx      <= i_idx;
    end
  end

endmodule

// File: rtl/flt_pds2_onboard_result_checker.sv
// Receives flt_pds2 result beats, checks them against the expected ROM and
// accumulates pass/fail, error count, timeout and overrun status.
module flt_pds2_onboard_result_checker
  import flt_pds2_onboard_pkg::*;
#(
  parameter int EXP_WIDTH       = EXP_W,
  parameter int MAN_WIDTH       = MAN_W,
  parameter int TDATA_OUT_WIDTH = TDATA_OUT_W,
  parameter int NUM_VECTORS     = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int ULP_TOL         = 1,
  parameter int TIMEOUT         = 1024,
  localparam int CNT_W          = $clog2(NUM_VECTORS + 1),
  localparam int TO_W           = $clog2(TIMEOUT + 1)
) (
  input  logic                       i_aclk,
  input  logic                       i_areset_n,
  input  logic                       i_start,
  input  logic [TDATA_OUT_WIDTH-1:0] i_axi4s_result_tdata,
  input  logic                       i_axi4s_result_tvalid,
  input  logic                       i_axi4s_result_tlast,
  output logic [ADDR_WIDTH-1:0]      o_exp_addr,
  input  logic [TDATA_OUT_WIDTH-1:0] i_exp_tdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_pass,
  output logic [CNT_W-1:0]           o_err_cnt,
  output logic [ADDR_WIDTH-1:0]      o_first_err_idx,
  output logic                       o_timeout,
  output logic                       o_overrun
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_idx;
  logic                       r_s1_valid;
  logic [TDATA_OUT_WIDTH-1:0] r_s1_data;
  logic                       r_s1_tlast;
  logic [ADDR_WIDTH-1:0]      r_s1_idx;
  logic [TO_W-1:0]            r_to_cnt;
  logic                       w_in_run;
  logic                       w_in_done;
  logic                       w_accept_run;
  logic                       w_accept_done;
  logic                       w_cmp_valid;
  logic                       w_cmp_mismatch;
  logic [ADDR_WIDTH-1:0]      w_cmp_idx;
  logic                       w_final;
  logic                       w_to_fire;

  assign w_in_run      = r_state == ST_RUN;
  assign w_in_done     = (r_state == ST_DONE_PASS) || (r_state == ST_DONE_FAIL);
  // A start in RUN drops the coincident beat; a start in DONE keeps it as vector 0.
  assign w_accept_run  = w_in_run && i_axi4s_result_tvalid && !i_start;
  assign w_accept_done = w_in_done && i_axi4s_result_tvalid && i_start;
  assign w_final       = w_in_run && w_cmp_valid && (w_cmp_idx == ADDR_WIDTH'(NUM_VECTORS - 1));
  assign w_to_fire     = w_in_run && !i_start && !w_accept_run && !w_final && (r_to_cnt == '0);

  assign o_exp_addr = i_start ? '0 : r_idx;
  assign o_busy     = w_in_run;
  assign o_done     = w_in_done;
  assign o_pass     = r_state == ST_DONE_PASS;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else if (w_final) begin
          w_state_nxt = ((o_err_cnt == '0) && !w_cmp_mismatch) ? ST_DONE_PASS : ST_DONE_FAIL;
        end else if (w_to_fire) begin
          w_state_nxt = ST_DONE_FAIL;
        end
      end
      ST_DONE_PASS, ST_DONE_FAIL: if (i_start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tlast <= 1'b0;
      r_s1_idx   <= '0;
    end else if (i_start) begin
      r_idx      <= w_accept_done ? ADDR_WIDTH'(1) : '0;
      r_s1_valid <= w_accept_done;
      r_s1_data  <= i_axi4s_result_tdata;
      r_s1_tlast <= i_axi4s_result_tlast;
      r_s1_idx   <= '0;
    end else if (w_accept_run) begin
      r_idx      <= r_idx + ADDR_WIDTH'(1);
      r_s1_valid <= 1'b1;
      r_s1_data  <= i_axi4s_result_tdata;
      r_s1_tlast <= i_axi4s_result_tlast;
      r_s1_idx   <= r_idx;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Idle-cycle down-counter; terminal count of zero means TIMEOUT idle cycles elapsed.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_to_cnt <= TO_W'(TIMEOUT - 1);
    end else if (i_start || w_accept_run) begin
      r_to_cnt <= TO_W'(TIMEOUT - 1);
    end else if (w_in_run && (r_to_cnt != '0)) begin
      r_to_cnt <= r_to_cnt - TO_W'(1);
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_err_cnt       <= '0;
      o_first_err_idx <= '0;
      o_timeout       <= 1'b0;
      o_overrun       <= 1'b0;
    end else if (i_start) begin
      o_err_cnt       <= '0;
      o_first_err_idx <= '0;
      o_timeout       <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      if (w_in_run && w_cmp_valid && w_cmp_mismatch) begin
        if (o_err_cnt == '0) o_first_err_idx <= w_cmp_idx;
        if (o_err_cnt != CNT_W'(NUM_VECTORS)) o_err_cnt <= o_err_cnt + CNT_W'(1);
      end
      if (w_to_fire) o_timeout <= 1'b1;
      if (w_in_done && i_axi4s_result_tvalid) o_overrun <= 1'b1;
    end
  end

  flt_pds2_result_cmp #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MAN_WIDTH      (MAN_WIDTH),
    .TDATA_OUT_WIDTH(TDATA_OUT_WIDTH),
    .NUM_VECTORS    (NUM_VECTORS),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .ULP_TOL        (ULP_TOL)
  ) u_cmp (
    .i_aclk    (i_aclk),
    .i_areset_n(i_areset_n),
    .i_clear   (i_start),
    .i_valid   (r_s1_valid),
    .i_res     (r_s1_data),
    .i_exp     (i_exp_tdata),
    .i_tlast   (r_s1_tlast),
    .i_idx     (r_s1_idx),
    .o_valid   (w_cmp_valid),
    .o_mismatch(w_cmp_mismatch),
    .o_idx     (w_cmp_idx)
  );

endmodule
